// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: fetch, debug and ROM signals shared by the instruction-ROM arbiter
interface imem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic              rom_ce;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_inst;
  modport slave (
    input  if_req, if_addr, if_flush, dbg_req, dbg_addr, rom_inst,
    output if_gnt, if_rvalid, if_rdata, dbg_gnt, dbg_rvalid, dbg_rdata, rom_ce, rom_addr
  );
  modport master (
    output if_req, if_addr, if_flush, dbg_req, dbg_addr, rom_inst,
    input  if_gnt, if_rvalid, if_rdata, dbg_gnt, dbg_rvalid, dbg_rdata, rom_ce, rom_addr
  );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: IF-priority ROM arbiter with debug starvation guard and registered responses
module imem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  imem_arbiter_if.slave  bus
);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  logic              if_rvalid_q, if_rvalid_d;
  logic              dbg_rvalid_q, dbg_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              force_dbg, if_gnt, dbg_gnt;
  // grants are gated by rst so nothing reaches the ROM while held in reset
  always_comb begin
    force_dbg    = rst && bus.dbg_req && (starve_cnt_q == LIM);
    dbg_gnt      = rst && bus.dbg_req && (!bus.if_req || force_dbg);
    if_gnt       = rst && bus.if_req && !dbg_gnt;
    if_rvalid_d  = if_gnt && !bus.if_flush;
    dbg_rvalid_d = dbg_gnt;
    if_rdata_d   = if_gnt ? bus.rom_inst : if_rdata_q;
    dbg_rdata_d  = dbg_gnt ? bus.rom_inst : dbg_rdata_q;
    starve_cnt_d = (!bus.dbg_req || dbg_gnt) ? 4'd0 :
                   (starve_cnt_q == LIM) ? starve_cnt_q : starve_cnt_q + 4'd1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rvalid_q  <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      if_rdata_q   <= '0;
      dbg_rdata_q  <= '0;
      starve_cnt_q <= 4'd0;
    end else begin
      if_rvalid_q  <= if_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end
  assign bus.if_gnt     = if_gnt;
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.rom_ce     = if_gnt || dbg_gnt;
  assign bus.rom_addr   = if_gnt ? bus.if_addr : dbg_gnt ? bus.dbg_addr : '0;
  assign bus.if_rvalid  = if_rvalid_q;
  assign bus.dbg_rvalid = dbg_rvalid_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.dbg_rdata  = dbg_rdata_q;
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed and random checks of imem_arbiter against a behavioural model
module tb_imem_arbiter;
  localparam int LIM = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  int denied = 0;
  logic g_dbg = 1'b0;
  logic e_if_rv = 1'b0, e_dbg_rv = 1'b0;
  logic [31:0] e_if_rd = '0, e_dbg_rd = '0;
  imem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  imem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return ((a >> 2) * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction
  assign bus.rom_inst = rom_word(bus.rom_addr);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  // one clock: grant checks mid-cycle, response checks just after the edge
  task automatic step();
    logic eg_if, eg_dbg;
    logic [31:0] ea;
    @(negedge clk);
    eg_dbg = rst && bus.dbg_req && (!bus.if_req || denied == LIM);
    eg_if  = rst && bus.if_req && !eg_dbg;
    ea = eg_if ? bus.if_addr : eg_dbg ? bus.dbg_addr : 32'd0;
    chk("if_gnt", 32'(bus.if_gnt), 32'(eg_if));
    chk("dbg_gnt", 32'(bus.dbg_gnt), 32'(eg_dbg));
    chk("rom_ce", 32'(bus.rom_ce), 32'(eg_if || eg_dbg));
    chk("rom_addr", bus.rom_addr, ea);
    denied = (rst && bus.dbg_req && !eg_dbg) ? denied + 1 : 0;
    if (denied > LIM) begin
      chk("starve_bound", 32'(denied), 32'(LIM));
      denied = LIM;
    end
    g_dbg = eg_dbg;
    if (rst) begin
      e_if_rv  = eg_if && !bus.if_flush;
      e_dbg_rv = eg_dbg;
      if (eg_if) e_if_rd = rom_word(ea);
      if (eg_dbg) e_dbg_rd = rom_word(ea);
    end
    @(posedge clk);
    #1;
    chk("if_rvalid", 32'(bus.if_rvalid), 32'(e_if_rv));
    chk("dbg_rvalid", 32'(bus.dbg_rvalid), 32'(e_dbg_rv));
    chk("if_rdata", bus.if_rdata, e_if_rd);
    chk("dbg_rdata", bus.dbg_rdata, e_dbg_rd);
  endtask
  task automatic async_reset();
    rst = 1'b0;
    #1;
    e_if_rv = 1'b0; e_dbg_rv = 1'b0; e_if_rd = '0; e_dbg_rd = '0; denied = 0;
    chk("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    chk("rst_dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);
    chk("rst_if_rdata", bus.if_rdata, 32'd0);
    chk("rst_dbg_rdata", bus.dbg_rdata, 32'd0);
    step();
    rst = 1'b1;
  endtask
  task automatic set(input logic ir, input logic [31:0] ia, input logic fl, input logic dr, input logic [31:0] da);
    bus.if_req = ir; bus.if_addr = ia; bus.if_flush = fl; bus.dbg_req = dr; bus.dbg_addr = da;
  endtask
  initial begin
    set(1'b1, 32'h10, 1'b0, 1'b0, 32'h0);
    step();
    step();
    rst = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      set(1'b1, 32'(i * 4), 1'b0, 1'b0, 32'h0);
      step();
    end
    set(1'b1, 32'h100, 1'b0, 1'b1, 32'h40);
    for (int i = 0; i < LIM; i++) begin
      step();
      chk("starve_denied", 32'(g_dbg), 32'd0);
    end
    step();
    chk("starve_forced", 32'(g_dbg), 32'd1);
    set(1'b1, 32'h104, 1'b0, 1'b0, 32'h0);
    step();
    set(1'b0, 32'h0, 1'b0, 1'b1, 32'h8);
    step();
    set(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    set(1'b1, 32'h20, 1'b1, 1'b0, 32'h0);
    step();
    set(1'b1, 32'h24, 1'b0, 1'b0, 32'h0);
    step();
    set(1'b1, 32'h28, 1'b0, 1'b1, 32'h44);
    step();
    async_reset();
    set(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    step();
    for (int i = 0; i < 3000; i++) begin
      if (!bus.dbg_req || g_dbg) begin
        bus.dbg_req  = ($urandom_range(0, 2) == 0);
        bus.dbg_addr = 32'($urandom_range(0, 255)) << 2;
      end else if ($urandom_range(0, 15) == 0) begin
        bus.dbg_req = 1'b0;
      end
      bus.if_req   = ($urandom_range(0, 9) != 0);
      bus.if_addr  = 32'($urandom_range(0, 255)) << 2;
      bus.if_flush = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 299) == 0) async_reset();
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
